// File: rtl/tap_master.sv
// tap_master: JTAG TAP initiator.
// Drives TMS/TDI into a target TAP and samples its TDO. A command either walks
// to a stable state, or walks to Shift-DR/IR, shifts cmd_len bits and parks in
// the matching Pause state. The shortest path comes from walking a mirrored
// copy of the 16-state TAP FSM. The mirror advances every edge from the TMS
// value just driven, so it always matches the target's state.
//
// Ports:
//   GCLK       clock, rising edge
//   TRST       asynchronous reset, active-high
//   cmd_valid  command request; accepted when cmd_valid && cmd_ready
//   cmd_ready  ~busy
//   cmd_state  target state (TAP encoding below)
//   cmd_len    bits to shift; 0 = navigate only
//   cmd_data   TDI payload, LSB first
//   tms, tdi   registered outputs to the target TAP
//   tdo        TDO from the target TAP
//   busy       command executing
//   done       one-cycle completion pulse
//   err        one-cycle pulse with done on a rejected command
//   rdata      captured TDO bits, LSB first
//   state_obs  mirrored TAP state
//
// state    | meaning
// TLR  (F) | Test-Logic-Reset
// RTI  (C) | Run-Test/Idle
// SelDR(7) | Select-DR-Scan
// CapDR(6) | Capture-DR
// ShDR (2) | Shift-DR
// Ex1DR(1) | Exit1-DR
// PaDR (3) | Pause-DR
// Ex2DR(0) | Exit2-DR
// UpDR (5) | Update-DR
// SelIR(4) | Select-IR-Scan
// CapIR(E) | Capture-IR
// ShIR (A) | Shift-IR
// Ex1IR(9) | Exit1-IR
// PaIR (B) | Pause-IR
// Ex2IR(8) | Exit2-IR
// UpIR (D) | Update-IR
module tap_master #(
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = 6
) (
   input  logic               GCLK,
   input  logic               TRST,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [3:0]         cmd_state,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               tms,
   output logic               tdi,
   input  logic               tdo,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [MAX_LEN-1:0] rdata,
   output logic [3:0]         state_obs
);

   typedef enum logic [3:0] {
      S_TLR    = 4'hF,
      S_RTI    = 4'hC,
      S_SEL_DR = 4'h7,
      S_CAP_DR = 4'h6,
      S_SH_DR  = 4'h2,
      S_EX1_DR = 4'h1,
      S_PA_DR  = 4'h3,
      S_EX2_DR = 4'h0,
      S_UP_DR  = 4'h5,
      S_SEL_IR = 4'h4,
      S_CAP_IR = 4'hE,
      S_SH_IR  = 4'hA,
      S_EX1_IR = 4'h9,
      S_PA_IR  = 4'hB,
      S_EX2_IR = 4'h8,
      S_UP_IR  = 4'hD
   } tap_state_t;

   function automatic tap_state_t tap_next(input tap_state_t s, input logic t);
      tap_state_t n;
      n = S_TLR;
      case (s)
         S_TLR:    n = t ? S_TLR    : S_RTI;
         S_RTI:    n = t ? S_SEL_DR : S_RTI;
         S_SEL_DR: n = t ? S_SEL_IR : S_CAP_DR;
         S_CAP_DR: n = t ? S_EX1_DR : S_SH_DR;
         S_SH_DR:  n = t ? S_EX1_DR : S_SH_DR;
         S_EX1_DR: n = t ? S_UP_DR  : S_PA_DR;
         S_PA_DR:  n = t ? S_EX2_DR : S_PA_DR;
         S_EX2_DR: n = t ? S_UP_DR  : S_SH_DR;
         S_UP_DR:  n = t ? S_SEL_DR : S_RTI;
         S_SEL_IR: n = t ? S_TLR    : S_CAP_IR;
         S_CAP_IR: n = t ? S_EX1_IR : S_SH_IR;
         S_SH_IR:  n = t ? S_EX1_IR : S_SH_IR;
         S_EX1_IR: n = t ? S_UP_IR  : S_PA_IR;
         S_PA_IR:  n = t ? S_EX2_IR : S_PA_IR;
         S_EX2_IR: n = t ? S_UP_IR  : S_SH_IR;
         S_UP_IR:  n = t ? S_SEL_DR : S_RTI;
         default:  n = S_TLR;
      endcase
      return n;
   endfunction

   // TMS for the next step of the shortest path from s toward tgt.
   function automatic logic tap_hop(input tap_state_t s, input tap_state_t tgt);
      logic h;
      h = 1'b1;
      case (s)
         S_TLR:              h = (tgt == S_TLR);
         S_SEL_DR:           h = !(tgt == S_SH_DR || tgt == S_PA_DR);
         S_SEL_IR:           h = !(tgt == S_SH_IR || tgt == S_PA_IR);
         S_CAP_DR, S_EX2_DR: h = (tgt != S_SH_DR);
         S_CAP_IR, S_EX2_IR: h = (tgt != S_SH_IR);
         S_EX1_DR:           h = (tgt != S_PA_DR);
         S_EX1_IR:           h = (tgt != S_PA_IR);
         S_UP_DR, S_UP_IR:   h = (tgt != S_RTI);
         default:            h = 1'b1;  // RTI, Shift and Pause always leave with TMS=1
      endcase
      return h;
   endfunction

   tap_state_t         r_state, w_state_nxt;
   tap_state_t         r_tgt, w_tgt_nxt;
   logic               r_tms, w_tms_nxt;
   logic               r_tdi, w_tdi_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_shift, w_shift_nxt;
   logic               r_done, w_done_nxt;
   logic               r_err, w_err_nxt;
   logic [LEN_W-1:0]   r_len, w_len_nxt;
   logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
   logic [MAX_LEN-1:0] r_data, w_data_nxt;
   logic [MAX_LEN-1:0] r_rdata, w_rdata_nxt;

   tap_state_t         w_n;
   tap_state_t         w_cmd_tgt;
   logic               w_cmd_is_shift;
   logic               w_legal;
   logic               w_reject;
   logic [LEN_W-1:0]   w_idx;

   always_ff @(posedge GCLK or posedge TRST) begin
      if (TRST) begin
         r_state <= S_TLR;
         r_tgt   <= S_TLR;
         r_tms   <= 1'b1;
         r_tdi   <= 1'b0;
         r_busy  <= 1'b0;
         r_shift <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tgt   <= w_tgt_nxt;
         r_tms   <= w_tms_nxt;
         r_tdi   <= w_tdi_nxt;
         r_busy  <= w_busy_nxt;
         r_shift <= w_shift_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_len   <= w_len_nxt;
         r_cnt   <= w_cnt_nxt;
         r_data  <= w_data_nxt;
         r_rdata <= w_rdata_nxt;
      end
   end

   always_comb begin
      w_n            = tap_next(r_state, r_tms);
      w_cmd_tgt      = tap_state_t'(cmd_state);
      w_cmd_is_shift = (w_cmd_tgt == S_SH_DR) || (w_cmd_tgt == S_SH_IR);
      w_legal        = (w_cmd_tgt == S_TLR)   || (w_cmd_tgt == S_RTI)   ||
                       (w_cmd_tgt == S_SH_DR) || (w_cmd_tgt == S_PA_DR) ||
                       (w_cmd_tgt == S_SH_IR) || (w_cmd_tgt == S_PA_IR);
      w_reject       = !w_legal || (cmd_len > LEN_W'(MAX_LEN)) ||
                       ((cmd_len != '0) && !w_cmd_is_shift);
      w_idx          = r_len - r_cnt;

      w_state_nxt = w_n;
      w_tms_nxt   = (w_n == S_TLR);  // idle hold keeps the mirror where it is
      w_tdi_nxt   = r_tdi;
      w_busy_nxt  = r_busy;
      w_shift_nxt = r_shift;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_tgt_nxt   = r_tgt;
      w_len_nxt   = r_len;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
      w_rdata_nxt = r_rdata;

      if (!r_busy) begin
         if (cmd_valid) begin
            if (w_reject) begin
               w_done_nxt = 1'b1;
               w_err_nxt  = 1'b1;
            end else if ((w_cmd_tgt == r_state) && (cmd_len == '0)) begin
               w_done_nxt = 1'b1;
            end else begin
               w_busy_nxt = 1'b1;
               w_tgt_nxt  = w_cmd_tgt;
               w_len_nxt  = cmd_len;
               w_data_nxt = cmd_data;
               if (cmd_len != '0)
                  w_rdata_nxt = '0;
               if (w_cmd_tgt == r_state) begin
                  // Already sitting in the requested Shift state: shift in place.
                  w_shift_nxt = 1'b1;
                  w_cnt_nxt   = cmd_len;
                  w_tdi_nxt   = cmd_data[0];
                  w_tms_nxt   = (cmd_len == LEN_W'(1));
               end else begin
                  w_tms_nxt = tap_hop(r_state, w_cmd_tgt);
               end
            end
         end
      end else if (r_shift) begin
         for (int i = 0; i < MAX_LEN; i++)
            if (w_idx == LEN_W'(i))
               w_rdata_nxt[i] = tdo;
         w_data_nxt = r_data >> 1;
         w_tdi_nxt  = r_data[1];
         w_cnt_nxt  = r_cnt - LEN_W'(1);
         if (r_cnt == LEN_W'(1)) begin
            // Last bit leaves for Exit1; retarget to the matching Pause state.
            w_shift_nxt = 1'b0;
            w_len_nxt   = '0;
            w_tgt_nxt   = (r_tgt == S_SH_IR) ? S_PA_IR : S_PA_DR;
            w_tms_nxt   = 1'b0;
         end else begin
            w_tms_nxt = (r_cnt == LEN_W'(2));
         end
      end else begin
         if (w_n != r_tgt) begin
            w_tms_nxt = tap_hop(w_n, r_tgt);
         end else if (r_len == '0) begin
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
         end else begin
            w_shift_nxt = 1'b1;
            w_cnt_nxt   = r_len;
            w_tdi_nxt   = r_data[0];
            w_tms_nxt   = (r_len == LEN_W'(1));
         end
      end
   end

   assign cmd_ready = ~r_busy;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign tms       = r_tms;
   assign tdi       = r_tdi;
   assign rdata     = r_rdata;
   assign state_obs = r_state;

endmodule
